// File: rtl/bp_nonsynth_pkg.sv
// Shared types and helpers for the bench-side commit/writeback driver.
package bp_nonsynth_pkg;

  localparam int unsigned bp_ts_width_lp = 8;

  typedef struct packed {
    logic [38:0] pc;
    logic [31:0] instr;
    logic        trap;
    logic [63:0] cause;
    logic        iwb;
    logic        fwb;
    logic [63:0] wdata;
    logic [6:0]  delay;
  } bp_nonsynth_commit_rec_s;

  typedef struct packed {
    logic                      fwb;
    logic [4:0]                rd;
    logic [63:0]               wdata;
    logic [bp_ts_width_lp-1:0] due;
  } bp_nonsynth_wb_entry_s;

  // Wrap-safe "ts has reached due": valid while the two are < 128 apart.
  function automatic logic due_reached(input logic [bp_ts_width_lp-1:0] ts,
                                       input logic [bp_ts_width_lp-1:0] due);
    logic [bp_ts_width_lp-1:0] diff;
    diff = ts - due;
    return ~diff[bp_ts_width_lp-1];
  endfunction

endpackage

// File: rtl/bp_nonsynth_wb_queue.sv
// In-order pending-writeback FIFO; the head is offered once its due time is reached.
module bp_nonsynth_wb_queue
  import bp_nonsynth_pkg::*;
#(
  parameter int els_p        = 8,
  parameter int data_width_p = 64,
  parameter int addr_width_p = 5
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            push_i,
  input  logic                            push_fwb_i,
  input  logic [addr_width_p-1:0]         push_rd_i,
  input  logic [data_width_p-1:0]         push_wdata_i,
  input  logic [bp_ts_width_lp-1:0]       push_due_i,
  input  logic [bp_ts_width_lp-1:0]       ts_i,
  input  logic                            pop_i,
  output logic                            head_v_o,
  output logic                            head_fwb_o,
  output logic [addr_width_p-1:0]         head_rd_o,
  output logic [data_width_p-1:0]         head_wdata_o,
  output logic                            full_o,
  output logic [$clog2(els_p+1)-1:0]      count_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p+1);

  logic [els_p-1:0]                     fwb_q, fwb_d;
  logic [els_p-1:0][addr_width_p-1:0]   rd_q, rd_d;
  logic [els_p-1:0][data_width_p-1:0]   wdata_q, wdata_d;
  logic [els_p-1:0][bp_ts_width_lp-1:0] due_q, due_d;
  logic [ptr_w-1:0]                     wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]                     rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0]                     count_q, count_d;

  always_comb begin
    fwb_d    = fwb_q;
    rd_d     = rd_q;
    wdata_d  = wdata_q;
    due_d    = due_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      fwb_d[wr_ptr_q]   = push_fwb_i;
      rd_d[wr_ptr_q]    = push_rd_i;
      wdata_d[wr_ptr_q] = push_wdata_i;
      due_d[wr_ptr_q]   = push_due_i;
      wr_ptr_d          = wr_ptr_q + ptr_w'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + ptr_w'(1);
    end
    if (push_i && !pop_i) begin
      count_d = count_q + cnt_w'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - cnt_w'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fwb_q    <= '0;
      rd_q     <= '0;
      wdata_q  <= '0;
      due_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fwb_q    <= fwb_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      due_q    <= due_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_v_o     = (count_q != '0) && due_reached(ts_i, due_q[rd_ptr_q]);
  assign head_fwb_o   = fwb_q[rd_ptr_q];
  assign head_rd_o    = rd_q[rd_ptr_q];
  assign head_wdata_o = wdata_q[rd_ptr_q];
  assign full_o       = (count_q == cnt_w'(els_p));
  assign count_o      = count_q;

endmodule

// File: rtl/bp_nonsynth_commit_driver.sv
// Producer end of the commit/writeback interface: one commit pulse per record,
// with each record's register writeback released later, in commit order.
module bp_nonsynth_commit_driver
  import bp_nonsynth_pkg::*;
#(
  parameter int vaddr_width_p    = 39,
  parameter int instr_width_p    = 32,
  parameter int dword_width_p    = 64,
  parameter int reg_addr_width_p = 5,
  parameter int wb_els_p         = 8,
  parameter int max_delay_p      = 63
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              rec_v_i,
  output logic                              rec_ready_o,
  input  logic [vaddr_width_p-1:0]          rec_pc_i,
  input  logic [instr_width_p-1:0]          rec_instr_i,
  input  logic                              rec_trap_i,
  input  logic [dword_width_p-1:0]          rec_cause_i,
  input  logic                              rec_iwb_i,
  input  logic                              rec_fwb_i,
  input  logic [dword_width_p-1:0]          rec_wdata_i,
  input  logic [6:0]                        rec_delay_i,
  output logic                              instret_o,
  output logic                              trap_o,
  output logic [vaddr_width_p-1:0]          commit_pc_o,
  output logic [instr_width_p-1:0]          commit_instr_o,
  output logic [dword_width_p-1:0]          cause_o,
  output logic                              ird_w_v_o,
  output logic [reg_addr_width_p-1:0]       ird_addr_o,
  output logic [dword_width_p-1:0]          ird_data_o,
  output logic                              frd_w_v_o,
  output logic [reg_addr_width_p-1:0]       frd_addr_o,
  output logic [dword_width_p-1:0]          frd_data_o,
  output logic [$clog2(wb_els_p+1)-1:0]     pending_o
);

  localparam logic [6:0] max_delay_lp = 7'(max_delay_p);

  logic                         run_q, run_d;
  logic [bp_ts_width_lp-1:0]    ts_q, ts_d;
  logic                         instret_q, instret_d;
  logic                         trap_q, trap_d;
  logic [vaddr_width_p-1:0]     pc_q, pc_d;
  logic [instr_width_p-1:0]     instr_q, instr_d;
  logic [dword_width_p-1:0]     cause_q, cause_d;

  logic                         accept;
  logic                         push;
  logic [bp_ts_width_lp-1:0]    due;
  logic                         full;
  logic                         head_v;
  logic                         head_fwb;
  logic [reg_addr_width_p-1:0]  head_rd;
  logic [dword_width_p-1:0]     head_wdata;

  // run_q holds ready low for the first cycle after reset release.
  assign rec_ready_o = run_q & ~full;
  assign accept      = rec_v_i & rec_ready_o;
  assign push        = accept & ~rec_trap_i & (rec_iwb_i | rec_fwb_i);
  assign due         = ts_q + 8'd1 + {1'b0, rec_delay_i};

  always_comb begin
    run_d     = 1'b1;
    ts_d      = ts_q + 8'd1;
    instret_d = accept & ~rec_trap_i;
    trap_d    = accept & rec_trap_i;
    pc_d      = pc_q;
    instr_d   = instr_q;
    cause_d   = cause_q;
    if (accept) begin
      pc_d    = rec_pc_i;
      instr_d = rec_instr_i;
      cause_d = rec_trap_i ? rec_cause_i : '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      run_q     <= 1'b0;
      ts_q      <= '0;
      instret_q <= 1'b0;
      trap_q    <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      cause_q   <= '0;
    end else begin
      run_q     <= run_d;
      ts_q      <= ts_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      cause_q   <= cause_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && accept) begin
      assert (rec_trap_i || !(rec_iwb_i && rec_fwb_i));
      assert (rec_delay_i <= max_delay_lp);
    end
  end

  // A record flagged for both register files is written to the FP file.
  bp_nonsynth_wb_queue #(
    .els_p       (wb_els_p),
    .data_width_p(dword_width_p),
    .addr_width_p(reg_addr_width_p)
  ) u_wb_queue (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_i      (push),
    .push_fwb_i  (rec_fwb_i),
    .push_rd_i   (rec_instr_i[11:7]),
    .push_wdata_i(rec_wdata_i),
    .push_due_i  (due),
    .ts_i        (ts_q),
    .pop_i       (head_v),
    .head_v_o    (head_v),
    .head_fwb_o  (head_fwb),
    .head_rd_o   (head_rd),
    .head_wdata_o(head_wdata),
    .full_o      (full),
    .count_o     (pending_o)
  );

  assign instret_o      = instret_q;
  assign trap_o         = trap_q;
  assign commit_pc_o    = pc_q;
  assign commit_instr_o = instr_q;
  assign cause_o        = cause_q;
  assign ird_w_v_o      = head_v & ~head_fwb;
  assign ird_addr_o     = head_rd;
  assign ird_data_o     = head_wdata;
  assign frd_w_v_o      = head_v & head_fwb;
  assign frd_addr_o     = head_rd;
  assign frd_data_o     = head_wdata;

endmodule

// File: tb/tb_bp_nonsynth_commit_driver.sv
// Directed + randomised bench for bp_nonsynth_commit_driver with a cycle-level
// scoreboard of expected commit pulses and writeback issue cycles.
module tb_bp_nonsynth_commit_driver;
  import bp_nonsynth_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        rec_v_i;
  logic        rec_ready_o;
  logic [38:0] rec_pc_i;
  logic [31:0] rec_instr_i;
  logic        rec_trap_i;
  logic [63:0] rec_cause_i;
  logic        rec_iwb_i;
  logic        rec_fwb_i;
  logic [63:0] rec_wdata_i;
  logic [6:0]  rec_delay_i;
  logic        instret_o, trap_o;
  logic [38:0] commit_pc_o;
  logic [31:0] commit_instr_o;
  logic [63:0] cause_o;
  logic        ird_w_v_o, frd_w_v_o;
  logic [4:0]  ird_addr_o, frd_addr_o;
  logic [63:0] ird_data_o, frd_data_o;
  logic [3:0]  pending_o;

  bp_nonsynth_commit_driver dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .rec_v_i(rec_v_i), .rec_ready_o(rec_ready_o),
    .rec_pc_i(rec_pc_i), .rec_instr_i(rec_instr_i), .rec_trap_i(rec_trap_i),
    .rec_cause_i(rec_cause_i), .rec_iwb_i(rec_iwb_i), .rec_fwb_i(rec_fwb_i),
    .rec_wdata_i(rec_wdata_i), .rec_delay_i(rec_delay_i),
    .instret_o(instret_o), .trap_o(trap_o), .commit_pc_o(commit_pc_o),
    .commit_instr_o(commit_instr_o), .cause_o(cause_o),
    .ird_w_v_o(ird_w_v_o), .ird_addr_o(ird_addr_o), .ird_data_o(ird_data_o),
    .frd_w_v_o(frd_w_v_o), .frd_addr_o(frd_addr_o), .frd_data_o(frd_data_o),
    .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: a writeback issues at max(commit cycle + delay, previous issue + 1).
  typedef struct {
    bit        fwb;
    bit [4:0]  rd;
    bit [63:0] wdata;
    int        issue;
  } exp_wb_t;

  exp_wb_t   mq[$];
  int        up = 0;
  int        last_issue = -1;
  bit        ec_v = 0;
  bit        ec_trap;
  bit [38:0] ec_pc;
  bit [31:0] ec_instr;
  bit [63:0] ec_cause;

  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      check("rst_flags", {instret_o, trap_o, ird_w_v_o, frd_w_v_o, rec_ready_o, pending_o}, '0);
      check("rst_commit", {commit_pc_o ^ 39'(cause_o), commit_instr_o}, '0);
      check("rst_cause", cause_o, '0);
      mq.delete();
      up = 0;
      last_issue = -1;
      ec_v = 0;
    end else begin
      bit      wb_exp;
      exp_wb_t h;
      up++;
      if (ec_v) begin
        check("instret", instret_o, !ec_trap);
        check("trap", trap_o, ec_trap);
        check("commit_pc", commit_pc_o, ec_pc);
        check("commit_instr", commit_instr_o, ec_instr);
        check("cause", cause_o, ec_cause);
      end else begin
        check("no_pulse", {instret_o, trap_o}, '0);
      end
      check("pending", pending_o, mq.size());
      check("ready", rec_ready_o, (up >= 2) && (mq.size() < 8));
      wb_exp = (mq.size() > 0) && (mq[0].issue == cyc);
      if (wb_exp) h = mq.pop_front();
      check("ird_v", ird_w_v_o, wb_exp && !h.fwb);
      check("frd_v", frd_w_v_o, wb_exp && h.fwb);
      if (wb_exp && !h.fwb) check("ird_addr_data", {ird_addr_o, ird_data_o}, {h.rd, h.wdata});
      if (wb_exp && h.fwb)  check("frd_addr_data", {frd_addr_o, frd_data_o}, {h.rd, h.wdata});
      ec_v = rec_v_i && rec_ready_o;
      if (ec_v) begin
        ec_trap  = rec_trap_i;
        ec_pc    = rec_pc_i;
        ec_instr = rec_instr_i;
        ec_cause = rec_trap_i ? rec_cause_i : 64'd0;
        if (!rec_trap_i && (rec_iwb_i || rec_fwb_i)) begin
          exp_wb_t e;
          e.issue = cyc + 1 + int'(rec_delay_i);
          if (e.issue <= last_issue) e.issue = last_issue + 1;
          last_issue = e.issue;
          e.fwb   = rec_fwb_i;
          e.rd    = rec_instr_i[11:7];
          e.wdata = rec_wdata_i;
          mq.push_back(e);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bp_nonsynth_commit_rec_s r);
    rec_pc_i    = r.pc;
    rec_instr_i = r.instr;
    rec_trap_i  = r.trap;
    rec_cause_i = r.cause;
    rec_iwb_i   = r.iwb;
    rec_fwb_i   = r.fwb;
    rec_wdata_i = r.wdata;
    rec_delay_i = r.delay;
  endtask

  // Call just after a rising edge; returns just after the accepting edge,
  // with commit_cyc = the cycle in which the commit pulse is visible.
  task automatic send(input bp_nonsynth_commit_rec_s r, output int commit_cyc);
    bit done = 0;
    drive(r);
    rec_v_i = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk_i);
      done = rec_ready_o;
      sync();
    end
    commit_cyc = cyc;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no acceptance, expected acceptance within 300 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    int guard = 0;
    do begin
      @(negedge clk_i);
      guard++;
    end while (cyc < c && guard < 2000);
    if (cyc != c) begin
      tests++;
      fails++;
      $display("FAIL wait_cyc: got cycle %0d, expected cycle %0d", cyc, c);
    end
  endtask

  function automatic bp_nonsynth_commit_rec_s mk(input bit iwb, input bit fwb, input bit [4:0] rd,
                                                 input bit [63:0] wdata, input int delay);
    bp_nonsynth_commit_rec_s r;
    r       = '0;
    r.pc    = 39'h0_4000_0000 + 39'(rd);
    r.instr = {20'h00000, rd, 7'h13};
    r.iwb   = iwb;
    r.fwb   = fwb;
    r.wdata = wdata;
    r.delay = 7'(delay);
    return r;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bp_nonsynth_commit_rec_s r;
    int rel, c, c1, c2, c3;
    int cf[8];

    // Reset with a valid record already presented.
    reset_n_i = 1'b0;
    r = mk(1'b0, 1'b0, 5'd3, 64'd0, 0);
    drive(r);
    rec_v_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    rel = cyc;
    wait_cyc(rel);
    check("ready_release0", rec_ready_o, 1'b0);
    wait_cyc(rel + 1);
    check("ready_release1", rec_ready_o, 1'b1);
    sync();
    rec_v_i = 1'b0;
    repeat (2) sync();

    // Single iwb, delay 0: writeback in the commit cycle.
    r = '0;
    r.pc = 39'h0_8000_0000;
    r.instr = 32'h00a00093;
    r.iwb = 1'b1;
    r.wdata = 64'd10;
    send(r, c);
    rec_v_i = 1'b0;
    wait_cyc(c);
    check("t2_instret", instret_o, 1'b1);
    check("t2_ird_v", ird_w_v_o, 1'b1);
    check("t2_ird_addr", ird_addr_o, 5'd1);
    check("t2_ird_data", ird_data_o, 64'd10);
    sync();

    // Three fwb back-to-back, delays 5/0/0: ordered issue at commit+5, +6, +7.
    send(mk(1'b0, 1'b1, 5'd4, 64'hA1, 5), c1);
    send(mk(1'b0, 1'b1, 5'd5, 64'hA2, 0), c2);
    send(mk(1'b0, 1'b1, 5'd6, 64'hA3, 0), c3);
    rec_v_i = 1'b0;
    check("t3_b2b", c3 - c1, 2);
    wait_cyc(c1 + 4);
    check("t3_not_yet", frd_w_v_o, 1'b0);
    wait_cyc(c1 + 5);
    check("t3_frd0", {frd_w_v_o, frd_addr_o, frd_data_o}, {1'b1, 5'd4, 64'hA1});
    check("t3_peak", pending_o, 3);
    wait_cyc(c1 + 6);
    check("t3_frd1", {frd_w_v_o, frd_addr_o, frd_data_o}, {1'b1, 5'd5, 64'hA2});
    wait_cyc(c1 + 7);
    check("t3_frd2", {frd_w_v_o, frd_addr_o, frd_data_o}, {1'b1, 5'd6, 64'hA3});
    sync();

    // Trap with iwb set: pulse only, nothing queued.
    r = mk(1'b1, 1'b0, 5'd7, 64'hDEAD, 0);
    r.trap = 1'b1;
    r.cause = 64'd2;
    send(r, c);
    rec_v_i = 1'b0;
    wait_cyc(c);
    check("t4_trap", {trap_o, instret_o}, 2'b10);
    check("t4_cause", cause_o, 64'd2);
    wait_cyc(c + 1);
    check("t4_no_wb", {ird_w_v_o, pending_o}, '0);
    sync();

    // Fill the queue with delay-63 writebacks.
    for (int k = 0; k < 8; k++) send(mk(1'b1, 1'b0, 5'(k + 8), 64'(100 + k), 63), cf[k]);
    rec_v_i = 1'b0;
    wait_cyc(cf[7]);
    check("t5_full_ready", rec_ready_o, 1'b0);
    check("t5_full_pending", pending_o, 8);
    wait_cyc(cf[0] + 63);
    check("t5_first_pop", {ird_w_v_o, ird_data_o, rec_ready_o}, {1'b1, 64'd100, 1'b0});
    wait_cyc(cf[0] + 64);
    check("t5_ready_back", rec_ready_o, 1'b1);
    check("t5_pending7", pending_o, 7);
    repeat (10) sync();

    // Reset while writebacks are queued: they must be discarded.
    send(mk(1'b1, 1'b0, 5'd2, 64'h55, 30), c);
    send(mk(1'b0, 1'b1, 5'd3, 64'h66, 30), c);
    rec_v_i = 1'b0;
    repeat (3) sync();
    reset_n_i = 1'b0;
    repeat (2) sync();
    reset_n_i = 1'b1;
    rel = cyc;
    wait_cyc(rel);
    check("t6_pending_cleared", pending_o, 0);
    repeat (40) sync();

    // Randomised stream crossing the 8-bit timestamp wrap.
    for (int k = 0; k < 90; k++) begin
      int sel;
      r = '0;
      r.pc    = 39'({$urandom(), $urandom()});
      r.instr = $urandom();
      r.trap  = ($urandom_range(0, 7) == 0);
      r.cause = {$urandom(), $urandom()};
      sel     = $urandom_range(0, 2);
      r.iwb   = (sel == 1);
      r.fwb   = (sel == 2);
      r.wdata = {$urandom(), $urandom()};
      r.delay = 7'($urandom_range(0, 63));
      if (k == 3) begin
        r.trap = 1'b0;
        r.iwb = 1'b1;
        r.fwb = 1'b0;
        r.instr[11:7] = 5'd0;
      end
      send(r, c);
      if ($urandom_range(0, 1) == 1) begin
        rec_v_i = 1'b0;
        repeat ($urandom_range(1, 3)) sync();
      end
    end
    rec_v_i = 1'b0;
    repeat (90) sync();
    check("drained", mq.size(), 0);
    check("wrapped", cyc > 300, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
